iq_sync_fifo: RTL and testbench
===============================

Name: iq_sync_fifo

Overview:
Single-clock, parametrised successor to the dual-clock complex I/Q FIFO, used inside one clock domain between the modem sample pipeline and the SPI/SMI packer.
- Stores 2×DATA_WIDTH I/Q words; I is in the upper half, Q in the lower half.
- All 2^ADDR_WIDTH entries are usable.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a runtime-selectable output byte/IQ swap.

Parameters:
ADDR_WIDTH, 9, log2 of depth; DEPTH = 2^ADDR_WIDTH entries.
DATA_WIDTH, 16, width of one I or Q component; must be a multiple of 8.
ALMOST_FULL_LVL, 2^ADDR_WIDTH-4, almost_full_o asserts when level >= this value.
ALMOST_EMPTY_LVL, 4, almost_empty_o asserts when level <= this value.

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous reset, active-high
wr_en_i  in  1  write request
wr_data_i  in  2*DATA_WIDTH  {I, Q}
rd_en_i  in  1  read request
swap_mode_i  in  2  output format: 00 raw, 01 byte-reverse each component, 10 swap I/Q, 11 both
clr_flags_i  in  1  synchronous clear of the sticky flags
rd_data_o  out  2*DATA_WIDTH  registered read data
rd_valid_o  out  1  one-cycle pulse; rd_data_o was updated this cycle
level_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
full_o / empty_o  out  1  level==DEPTH / level==0
almost_full_o / almost_empty_o  out  1  threshold flags
overflow_o / underflow_o  out  1  sticky error flags

Behaviour:
- Reset (async assert, sync release) returns the block to this state:
  - pointers=0, level_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0
  - rd_data_o=0, rd_valid_o=0, overflow_o=0, underflow_o=0
  - memory contents are not reset.
- Reset mid-operation discards all stored entries. The first write after release lands at address 0.
- Pointers are ADDR_WIDTH+1 bits; the MSB is a wrap bit and addresses use the low ADDR_WIDTH bits. Wrap-around is natural modulo 2^(ADDR_WIDTH+1).
- Write accept: wr_en_i && !full_o. The entry is stored on this edge.
  - wr_en_i while full: data is dropped, the pointer holds, overflow_o sets on the next edge.
- Read accept: rd_en_i && !empty_o.
  - rd_data_o is loaded on the same edge with the formatted entry (1-cycle latency).
  - rd_valid_o=1 for exactly that cycle.
- rd_en_i while empty: rd_data_o holds, rd_valid_o=0, underflow_o sets.
- Simultaneous write and read:
  - When empty: the write is accepted and the read is rejected (underflow). No fall-through.
  - When full: both are accepted and level is unchanged.
  - Otherwise: both are accepted and level is unchanged.
- level_o, full_o, empty_o, almost_full_o and almost_empty_o are registered. Each is computed from the next-state level, so it is exact in the cycle after the access.
- Formatting (combinational on the memory word, captured into rd_data_o):
  - bit0 of swap_mode_i reverses byte order inside each component.
  - bit1 exchanges the I and Q halves.
  - When both are set, the byte reverse is applied first, then the I/Q exchange.
  - swap_mode_i is sampled on the read-accept edge only.
- Sticky flags clear when clr_flags_i=1. A new error event in the same cycle wins, and the flag stays 1.

Optional Feature:
IQ_FIFO_PEAK_LEVEL_EN
- Defined: adds output peak_level_o [ADDR_WIDTH:0], reset 0.
  - It is a registered maximum of level_o.
  - clr_flags_i reloads it with the current level.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package iq_fifo_pkg holds:
  - swap mode constants SWAP_RAW=2'b00, SWAP_BYTES=2'b01, SWAP_IQ=2'b10, SWAP_BOTH=2'b11
  - a function for the level width (ADDR_WIDTH+1).
- Sub-module iq_word_swap: a purely combinational formatter parametrised by DATA_WIDTH, taking swap_mode_i. It is reused by the TX path.
- The memory stays inline as inferred RAM with a registered read.

Test Plan:
ADDR_WIDTH=2 (depth 4), DATA_WIDTH=16, ALMOST_FULL_LVL=3, ALMOST_EMPTY_LVL=1.
1. Fill and drain: write 0x11112222, 0x33334444, 0x55556666, 0x77778888.
   - After the 4th write: full_o=1, level_o=4, almost_full_o=1.
   - Then read 4 times with swap 00: the words return in the same order, each 1 cycle after rd_en_i with a rd_valid_o pulse; empty_o=1 after the last read.
2. Overflow: with the FIFO full, write 0xDEADBEEF.
   - level_o stays 4 and overflow_o=1.
   - The 4 reads do not return 0xDEADBEEF.
   - clr_flags_i then clears overflow_o.
3. Underflow: with the FIFO empty, assert rd_en_i.
   - rd_valid_o=0, rd_data_o unchanged, underflow_o=1.
   - Simultaneous write+read while empty: level_o becomes 1 and underflow_o=1.
4. Swap modes: store 0x1234ABCD four times, then read once with each mode 00, 01, 10, 11.
   - Expected outputs: 0x1234ABCD, 0x3412CDAB, 0xABCD1234, 0xCDAB3412.
5. Wrap and concurrency:
   - Stream 20 writes with reads enabled from cycle 2; check order is preserved across pointer wrap and level_o stays at 1–2.
   - With the FIFO full, a simultaneous read+write keeps full_o=1.
6. Async reset mid-stream: assert rst_i between edges with level 3.
   - All outputs reach reset values immediately.
   - After release, write 0xA5A5A5A5 then read it back.
   - With IQ_FIFO_PEAK_LEVEL_EN defined, peak_level_o=0 after the reset and 1 after that write.

Source files
------------

// File: rtl/iq_fifo_pkg.sv
// ----------------------------------------------------------------------------
// iq_fifo_pkg
// Shared definitions for the single-clock I/Q FIFO and its output formatter.
//   SWAP_*       : encodings of the 2-bit output-format selector
//                  (bit0 = byte reverse per component, bit1 = I/Q exchange)
//   level_width  : width of pointers/occupancy for a given address width
//                  (one extra bit so that a full FIFO is distinguishable)
// ----------------------------------------------------------------------------
package iq_fifo_pkg;

    localparam logic [1:0] SWAP_RAW   = 2'b00;
    localparam logic [1:0] SWAP_BYTES = 2'b01;
    localparam logic [1:0] SWAP_IQ    = 2'b10;
    localparam logic [1:0] SWAP_BOTH  = 2'b11;

    function automatic int unsigned level_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage : iq_fifo_pkg

// File: rtl/iq_word_swap.sv
// ----------------------------------------------------------------------------
// iq_word_swap
// Purely combinational I/Q word formatter, shared with the TX path.
// Ports:
//   swap_mode_i [1:0]           : bit0 reverses bytes inside each component,
//                                 bit1 exchanges the I (upper) and Q (lower)
//                                 halves; with both set the byte reverse is
//                                 applied first, then the exchange
//   word_i  [2*DATA_WIDTH-1:0]  : {I, Q} input word
//   word_o  [2*DATA_WIDTH-1:0]  : formatted word
// DATA_WIDTH must be a multiple of 8.
// ----------------------------------------------------------------------------
module iq_word_swap
    import iq_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [1:0]              swap_mode_i,
    input  logic [2*DATA_WIDTH-1:0] word_i,
    output logic [2*DATA_WIDTH-1:0] word_o
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] i_raw;
    logic [DATA_WIDTH-1:0] q_raw;
    logic [DATA_WIDTH-1:0] i_rev;
    logic [DATA_WIDTH-1:0] q_rev;
    logic [DATA_WIDTH-1:0] i_sel;
    logic [DATA_WIDTH-1:0] q_sel;

    assign i_raw = word_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign q_raw = word_i[DATA_WIDTH-1:0];

    // Byte gi of the reversed component is byte NBYTES-1-gi of the original.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign i_rev[gi*8 +: 8] = i_raw[(NBYTES-1-gi)*8 +: 8];
            assign q_rev[gi*8 +: 8] = q_raw[(NBYTES-1-gi)*8 +: 8];
        end
    endgenerate

    always_comb begin
        i_sel  = i_raw;
        q_sel  = q_raw;
        word_o = {i_raw, q_raw};
        if ((swap_mode_i & SWAP_BYTES) != SWAP_RAW) begin
            i_sel = i_rev;
            q_sel = q_rev;
        end
        if ((swap_mode_i & SWAP_IQ) != SWAP_RAW) begin
            word_o = {q_sel, i_sel};
        end else begin
            word_o = {i_sel, q_sel};
        end
    end

endmodule : iq_word_swap

// File: rtl/iq_sync_fifo.sv
// ----------------------------------------------------------------------------
// iq_sync_fifo
// Single-clock FIFO for packed {I, Q} sample words between the modem sample
// pipeline and the SPI/SMI packer. All 2^ADDR_WIDTH entries are usable.
// Ports:
//   clk_i, rst_i           : clock (rising edge), async active-high reset
//   wr_en_i, wr_data_i     : write request and {I, Q} data
//   rd_en_i                : read request (1-cycle latency to rd_data_o)
//   swap_mode_i            : output format, sampled on the read-accept edge
//   clr_flags_i            : clears sticky overflow/underflow
//   rd_data_o, rd_valid_o  : registered read data and its one-cycle strobe
//   level_o                : occupancy 0..DEPTH
//   full_o, empty_o        : level == DEPTH / level == 0
//   almost_full_o/_empty_o : level >= ALMOST_FULL_LVL / <= ALMOST_EMPTY_LVL
//   overflow_o/underflow_o : sticky error flags
// Optional: define IQ_FIFO_PEAK_LEVEL_EN to add peak_level_o, a registered
// running maximum of level_o that clr_flags_i reloads with the current level.
// ----------------------------------------------------------------------------
module iq_sync_fifo
    import iq_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH       = 9,
    parameter int DATA_WIDTH       = 16,
    parameter int ALMOST_FULL_LVL  = 2**ADDR_WIDTH - 4,
    parameter int ALMOST_EMPTY_LVL = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [2*DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [1:0]            swap_mode_i,
    input  logic                  clr_flags_i,
    output logic [2*DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
`ifdef IQ_FIFO_PEAK_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   peak_level_o
`endif
);

    localparam int LW    = level_width(ADDR_WIDTH);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int WW    = 2*DATA_WIDTH;

    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL    = LW'(ALMOST_FULL_LVL);
    localparam logic [LW-1:0] AE_LVL    = LW'(ALMOST_EMPTY_LVL);
    localparam logic [LW-1:0] ONE       = LW'(1);

    logic [WW-1:0]  mem_q [DEPTH];

    logic [LW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           full_q, empty_q, afull_q, aempty_q;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic [WW-1:0]  rd_data_q;
    logic           rd_valid_q;

    logic           wr_acc;
    logic           rd_acc;
    logic [WW-1:0]  mem_word;
    logic [WW-1:0]  fmt_word;

    // When full a read is always acceptable (not empty), so a concurrent
    // write can take the slot the read frees on the same edge.
    always_comb begin
        wr_acc      = wr_en_i && (!full_q || rd_en_i);
        rd_acc      = rd_en_i && !empty_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase
        // A new error in the same cycle as a clear keeps the flag set.
        overflow_d  = (overflow_q  && !clr_flags_i) || (wr_en_i && !wr_acc);
        underflow_d = (underflow_q && !clr_flags_i) || (rd_en_i && !rd_acc);
    end

    // Storage: no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
        end
    end

    // When full with a concurrent write, read and write hit the same address;
    // the read sees the old entry, which is the one being dequeued.
    assign mem_word = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    iq_word_swap #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_swap (
        .swap_mode_i (swap_mode_i),
        .word_i      (mem_word),
        .word_o      (fmt_word)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= (level_d == DEPTH_LVL);
            empty_q     <= (level_d == '0);
            afull_q     <= (level_d >= AF_LVL);
            aempty_q    <= (level_d <= AE_LVL);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= fmt_word;
            end
        end
    end

    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign level_o        = level_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

`ifdef IQ_FIFO_PEAK_LEVEL_EN
    logic [LW-1:0] peak_q;

    // Tracks level_o, so it lags level_o by one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_q <= '0;
        end else if (clr_flags_i) begin
            peak_q <= level_q;
        end else if (level_q > peak_q) begin
            peak_q <= level_q;
        end
    end

    assign peak_level_o = peak_q;
`endif

endmodule : iq_sync_fifo

// File: tb/tb_iq_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_iq_sync_fifo
// Directed bench for iq_sync_fifo (depth 4). Inputs change and flags are
// checked on the falling edge; expected read words are queued when a read is
// issued and a monitor compares them whenever rd_valid_o is seen.
// ----------------------------------------------------------------------------
module tb_iq_sync_fifo;

    localparam int AW = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_data = '0;
    logic          rd_en = 1'b0;
    logic [1:0]    swap = 2'b00;
    logic          clr = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [AW:0]   level;
    logic          full, empty, afull, aempty, ovf, unf;
`ifdef IQ_FIFO_PEAK_LEVEL_EN
    logic [AW:0]   peak;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   exp_q [$];

    always #5 clk = ~clk;

    iq_sync_fifo #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .ALMOST_FULL_LVL  (3),
        .ALMOST_EMPTY_LVL (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .rd_en_i        (rd_en),
        .swap_mode_i    (swap),
        .clr_flags_i    (clr),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .level_o        (level),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (afull),
        .almost_empty_o (aempty),
        .overflow_o     (ovf),
        .underflow_o    (unf)
`ifdef IQ_FIFO_PEAK_LEVEL_EN
        ,
        .peak_level_o   (peak)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // One clock: drive inputs, then wait for the following falling edge.
    task automatic cyc(input logic w, input logic [31:0] d, input logic r,
                       input logic [1:0] m, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        swap    = m;
        clr     = c;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic rd_exp(input logic [31:0] e, input logic [1:0] m);
        exp_q.push_back(e);
        cyc(1'b0, 32'h0, 1'b1, m, 1'b0);
    endtask

    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rd_valid_unexpected: got data 0x%08h, required no valid at %0t",
                             rd_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e);
                end
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_level"},    32'(level),  32'd0);
        chk({tag, "_empty"},    32'(empty),  32'd1);
        chk({tag, "_aempty"},   32'(aempty), 32'd1);
        chk({tag, "_full"},     32'(full),   32'd0);
        chk({tag, "_afull"},    32'(afull),  32'd0);
        chk({tag, "_rd_data"},  rd_data,     32'h0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_ovf"},      32'(ovf),    32'd0);
        chk({tag, "_unf"},      32'(unf),    32'd0);
`ifdef IQ_FIFO_PEAK_LEVEL_EN
        chk({tag, "_peak"},     32'(peak),   32'd0);
`endif
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        rst = 1'b0;
        @(negedge clk);

        // 1. Fill and drain
        cyc(1'b1, 32'h11112222, 1'b0, 2'b00, 1'b0);
        chk("t1_aempty_lvl1", 32'(aempty), 32'd1);
        cyc(1'b1, 32'h33334444, 1'b0, 2'b00, 1'b0);
        chk("t1_aempty_lvl2", 32'(aempty), 32'd0);
        cyc(1'b1, 32'h55556666, 1'b0, 2'b00, 1'b0);
        chk("t1_afull_lvl3", 32'(afull), 32'd1);
        chk("t1_full_lvl3",  32'(full),  32'd0);
        cyc(1'b1, 32'h77778888, 1'b0, 2'b00, 1'b0);
        chk("t1_full",  32'(full),  32'd1);
        chk("t1_level", 32'(level), 32'd4);
        chk("t1_afull", 32'(afull), 32'd1);
        rd_exp(32'h11112222, 2'b00);
        rd_exp(32'h33334444, 2'b00);
        rd_exp(32'h55556666, 2'b00);
        rd_exp(32'h77778888, 2'b00);
        chk("t1_empty",       32'(empty), 32'd1);
        chk("t1_level_drain", 32'(level), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b0);

        // 2. Overflow
        cyc(1'b1, 32'h0101AAAA, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 32'h0202BBBB, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 32'h0303CCCC, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 32'h0404DDDD, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 2'b00, 1'b0);
        chk("t2_level", 32'(level), 32'd4);
        chk("t2_ovf",   32'(ovf),   32'd1);
        chk("t2_full",  32'(full),  32'd1);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b1);
        chk("t2_ovf_clr", 32'(ovf), 32'd0);
        rd_exp(32'h0101AAAA, 2'b00);
        rd_exp(32'h0202BBBB, 2'b00);
        rd_exp(32'h0303CCCC, 2'b00);
        rd_exp(32'h0404DDDD, 2'b00);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b0);

        // 3. Underflow
        cyc(1'b0, 32'h0, 1'b1, 2'b00, 1'b0);
        chk("t3_rd_valid", 32'(rd_valid), 32'd0);
        chk("t3_rd_hold",  rd_data,       32'h0404DDDD);
        chk("t3_unf",      32'(unf),      32'd1);
        cyc(1'b0, 32'h0, 1'b1, 2'b00, 1'b1);
        chk("t3_unf_clr_vs_event", 32'(unf), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b1);
        chk("t3_unf_clr", 32'(unf), 32'd0);
        cyc(1'b1, 32'h5A5A0001, 1'b1, 2'b00, 1'b0);
        chk("t3_wr_rd_empty_level", 32'(level), 32'd1);
        chk("t3_wr_rd_empty_unf",   32'(unf),   32'd1);
        chk("t3_wr_rd_empty_flag",  32'(empty), 32'd0);
        rd_exp(32'h5A5A0001, 2'b00);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b1);

        // 4. Swap modes
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h1234ABCD, 1'b0, 2'b00, 1'b0);
        end
        rd_exp(32'h1234ABCD, 2'b00);
        rd_exp(32'h3412CDAB, 2'b01);
        rd_exp(32'hABCD1234, 2'b10);
        rd_exp(32'hCDAB3412, 2'b11);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b0);

        // 5. Wrap and concurrency
        for (int i = 0; i < 20; i++) begin
            if (i >= 1) begin
                exp_q.push_back(32'h00050000 + 32'(i - 1));
            end
            cyc(1'b1, 32'h00050000 + 32'(i), (i >= 1), 2'b00, 1'b0);
            chk("t5_stream_level", 32'(level), 32'd1);
        end
        rd_exp(32'h00050013, 2'b00);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h00060000 + 32'(i), 1'b0, 2'b00, 1'b0);
        end
        exp_q.push_back(32'h00060000);
        cyc(1'b1, 32'h00060004, 1'b1, 2'b00, 1'b0);
        chk("t5_full_rw_full",  32'(full),  32'd1);
        chk("t5_full_rw_level", 32'(level), 32'd4);
        chk("t5_full_rw_ovf",   32'(ovf),   32'd0);
        rd_exp(32'h00060001, 2'b00);
        rd_exp(32'h00060002, 2'b00);
        rd_exp(32'h00060003, 2'b00);
        rd_exp(32'h00060004, 2'b00);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        chk("t5_empty", 32'(empty), 32'd1);

        // 6. Async reset mid-stream
        cyc(1'b1, 32'h00070000, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 32'h00070001, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 32'h00070002, 1'b0, 2'b00, 1'b0);
        chk("t6_level_pre", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("t6_async");
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 32'hA5A5A5A5, 1'b0, 2'b00, 1'b0);
        chk("t6_level_post", 32'(level), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
`ifdef IQ_FIFO_PEAK_LEVEL_EN
        chk("t6_peak", 32'(peak), 32'd1);
`endif
        rd_exp(32'hA5A5A5A5, 2'b00);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        chk("outstanding_reads", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_iq_sync_fifo
